// File: rtl/jk_reg_bank.sv
// Multi-bit JK register bank: per-bit JK flops that share storage with
// parallel load, synchronous up-count (JK toggle chain) and serial left-shift.
module jk_reg_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             ser_out,
    output logic             tc
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             carry;

    always_comb begin
        q_d   = q_q;
        carry = 1'b1;
        if (en) begin
            case (mode)
                MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({j[i], k[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                MODE_LOAD: q_d = d;
                MODE_COUNT: begin
                    // bit i toggles only when every lower bit is already 1
                    for (int i = 0; i < WIDTH; i++) begin
                        if (carry) begin
                            q_d[i] = ~q_q[i];
                        end
                        carry = carry & q_q[i];
                    end
                end
                MODE_SHIFT: q_d = {q_q[WIDTH-2:0], ser_in};
                default:    q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign q_bar   = ~q_q;
    assign ser_out = q_q[WIDTH-1];
    assign tc      = en && (mode == MODE_COUNT) && (&q_q);

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=4): directed scenarios then random stimulus.
module tb_jk_reg_bank;

    localparam int unsigned W = 4;
    localparam logic [W-1:0] RST_VAL = 4'b0000;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] d;
    logic         ser_in;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic         ser_out;
    logic         tc;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] mq;

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RST_VAL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .d       (d),
        .ser_in  (ser_in),
        .q       (q),
        .q_bar   (q_bar),
        .ser_out (ser_out),
        .tc      (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: next q computed from the operation rules with plain arithmetic.
    function automatic logic [W-1:0] model(input logic [W-1:0] cur, input logic r, input logic e,
                                           input logic [1:0] m, input logic [W-1:0] jj,
                                           input logic [W-1:0] kk, input logic [W-1:0] dd,
                                           input logic s);
        logic [W-1:0] res;
        if (!r)      res = RST_VAL;
        else if (!e) res = cur;
        else begin
            case (m)
                2'd0:    res = (cur & ~kk) | (~cur & jj);
                2'd1:    res = dd;
                2'd2:    res = W'((int'(cur) + 1) % (1 << W));
                default: res = {cur[W-2:0], s};
            endcase
        end
        return res;
    endfunction

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] jj, input logic [W-1:0] kk,
                        input logic [W-1:0] dd, input logic s, input string name);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; mode = m; j = jj; k = kk; d = dd; ser_in = s;
        mq = model(mq, r, e, m, jj, kk, dd, s);
        x.q    = mq;
        x.tc   = e && (m == 2'd2) && (mq == {W{1'b1}});
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every edge that has an outstanding expectation is checked just after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk({x.name, ".q"},       q,                x.q);
                chk({x.name, ".q_bar"},   q_bar,            ~x.q);
                chk({x.name, ".ser_out"}, {3'b000, ser_out}, {3'b000, x.q[W-1]});
                chk({x.name, ".tc"},      {3'b000, tc},      {3'b000, x.tc});
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; j = '0; k = '0; d = '0; ser_in = 1'b0;
        mq = RST_VAL;

        step(0, 1, 2'd1, 4'h0, 4'h0, 4'hF, 0, "reset0");
        step(0, 1, 2'd1, 4'h0, 4'h0, 4'hF, 0, "reset1");

        step(1, 1, 2'd1, 4'h0, 4'h0, 4'b0101, 0, "jk_load");
        step(1, 1, 2'd0, 4'b0011, 4'b0110, 4'hF, 1, "jk_a");
        step(1, 1, 2'd0, 4'b0011, 4'b0110, 4'hF, 1, "jk_b");

        step(1, 1, 2'd1, 4'h0, 4'h0, 4'hD, 0, "cnt_load");
        for (int i = 0; i < 5; i++) step(1, 1, 2'd2, 4'hF, 4'h0, 4'h0, 1, "cnt");
        for (int i = 0; i < 3; i++) step(1, 0, 2'd2, 4'hF, 4'hF, 4'h5, 1, "cnt_hold");

        step(1, 1, 2'd1, 4'h0, 4'h0, 4'b1000, 0, "sh_load");
        step(1, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1, "sh1");
        step(1, 1, 2'd3, 4'hF, 4'hF, 4'hF, 0, "sh2");
        step(1, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1, "sh3");
        step(1, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1, "sh4");

        step(1, 1, 2'd1, 4'h0, 4'h0, 4'h5, 0, "rc_load");
        step(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0, "rc_cnt");
        step(0, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0, "rc_rst");
        step(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0, "rc_resume");

        step(1, 0, 2'd1, 4'h3, 4'hC, 4'hA, 1, "iso_hold");
        step(1, 1, 2'd1, 4'h3, 4'hC, 4'hA, 1, "iso_load");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), "rand");
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
